// File: rtl/ex_div.sv
// Multi-cycle 32-bit signed/unsigned divider for the EX stage.
// Restoring shift-subtract, one quotient bit per clock; result = {remainder, quotient}.
module ex_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] part_q, part_d;       // {partial remainder[32:0], quotient/dividend[31:0]}
  logic [31:0] divisor_q, divisor_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [63:0] result_d;
  logic        ready_d;

  logic [31:0] abs_op1, abs_op2;
  logic [64:0] shifted;
  logic [33:0] diff;
  logic [31:0] quo_fix, rem_fix;

  assign abs_op1 = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
  assign abs_op2 = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;

  // Bit 64 is always zero after a step (remainder < divisor), so the shift drops nothing.
  assign shifted = part_q << 1;
  assign diff    = {1'b0, shifted[64:32]} - {2'b00, divisor_q};
  assign quo_fix = q_neg_q ? -part_q[31:0]  : part_q[31:0];
  assign rem_fix = r_neg_q ? -part_q[63:32] : part_q[63:32];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    part_d    = part_q;
    divisor_d = divisor_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    result_d  = result_o;
    ready_d   = ready_o;

    unique case (state_q)
      FREE: begin
        result_d = 64'h0;
        ready_d  = 1'b0;
        if (start_i && !annul_i) begin
          part_d    = {33'h0, abs_op1};
          divisor_d = abs_op2;
          q_neg_d   = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
          r_neg_d   = signed_div_i && opdata1_i[31];
          cnt_d     = 6'd0;
          state_d   = (opdata2_i == 32'h0) ? BYZERO : ON;
        end
      end

      BYZERO: begin
        if (annul_i) begin
          state_d  = FREE;
          cnt_d    = 6'd0;
          result_d = 64'h0;
          ready_d  = 1'b0;
        end else begin
          state_d  = END;
          result_d = 64'h0;
          ready_d  = 1'b1;
        end
      end

      ON: begin
        if (annul_i) begin
          state_d  = FREE;
          cnt_d    = 6'd0;
          result_d = 64'h0;
          ready_d  = 1'b0;
        end else if (cnt_q != 6'd32) begin
          // A negative trial difference means the divisor did not fit: keep the shifted value.
          part_d = diff[33] ? shifted : {diff[32:0], shifted[31:1], 1'b1};
          cnt_d  = cnt_q + 6'd1;
        end else begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
          state_d  = END;
        end
      end

      END: begin
        if (!start_i) begin
          state_d  = FREE;
          cnt_d    = 6'd0;
          result_d = 64'h0;
          ready_d  = 1'b0;
        end
      end

      default: state_d = FREE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FREE;
      cnt_q     <= 6'd0;
      part_q    <= 65'h0;
      divisor_q <= 32'h0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      result_o  <= 64'h0;
      ready_o   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      part_q    <= part_d;
      divisor_q <= divisor_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      result_o  <= result_d;
      ready_o   <= ready_d;
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Directed self-checking bench for ex_div: latency, signed/unsigned results,
// divide-by-zero, annul, END hold/release and asynchronous reset.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_tests = 0;
  int n_fail  = 0;

  ex_div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Start one division at the next edge (edge 1), scramble operands after it,
  // and wait for ready; then check END hold (annul ignored) and release.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
    int n;
    n = 0;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
      end
      if (ready_o) break;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " result"}, result_o, exp_res);
    annul_i = 1'b1;
    @(negedge clk);
    check({tag, " hold"}, {result_o[62:0], ready_o}, {exp_res[62:0], 1'b1});
    annul_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    check({tag, " release"}, {result_o[62:0], ready_o}, 64'h0);
  endtask

  initial begin
    int n;
    logic seen_ready;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #12;
    check("reset state", {result_o[62:0], ready_o}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Idle in FREE: start low, then start high with annul high.
    opdata1_i = 32'd100; opdata2_i = 32'd7;
    repeat (3) @(negedge clk);
    check("idle no start", {result_o[62:0], ready_o}, 64'h0);
    start_i = 1'b1; annul_i = 1'b1;
    repeat (40) @(negedge clk);
    check("idle annul", {result_o[62:0], ready_o}, 64'h0);
    start_i = 1'b0; annul_i = 1'b0;
    @(negedge clk);

    run_div("u 100/7",      1'b0, 32'd100,      32'd7,        {32'd2, 32'd14}, 34);
    run_div("s -7/2",       1'b1, 32'hFFFFFFF9, 32'h2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 34);
    run_div("s 7/-2",       1'b1, 32'h7,        32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD}, 34);
    run_div("s -100/-7",    1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'h0000000E}, 34);
    run_div("s min/-1",     1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 34);
    run_div("s min/1",      1'b1, 32'h80000000, 32'h1,        {32'h0, 32'h80000000}, 34);
    run_div("u max/1",      1'b0, 32'hFFFFFFFF, 32'h1,        {32'h0, 32'hFFFFFFFF}, 34);
    run_div("u 5/9",        1'b0, 32'd5,        32'd9,        {32'd5, 32'd0}, 34);
    run_div("u max/-1",     1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'h0, 32'h1}, 34);
    run_div("u x/0",        1'b0, 32'd1234,     32'd0,        64'h0, 2);
    run_div("s x/0",        1'b1, 32'hFFFFFFF0, 32'd0,        64'h0, 2);

    // Annul during ON: pulse at edge 10, back in FREE at edge 11, no result.
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    start_i = 1'b1;
    seen_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      seen_ready |= ready_o;
    end
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul free", {result_o[62:0], ready_o}, 64'h0);
    check("annul no ready", 64'(seen_ready), 64'h0);
    run_div("u after annul", 1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 34);

    // Annul during BYZERO.
    signed_div_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd0;
    start_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    check("annul byzero", {result_o[62:0], ready_o}, 64'h0);
    @(negedge clk);

    // Reset mid-ON (cnt = 20), between edges.
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    start_i = 1'b1;
    repeat (21) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst mid on", {result_o[62:0], ready_o}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    run_div("u 9/3 after rst", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34);

    // Reset while in END clears the held result immediately.
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5;
    start_i = 1'b1;
    n = 0;
    while (n < 40 && !ready_o) begin
      @(negedge clk);
      n++;
    end
    check("end before rst", {result_o[62:0], ready_o}, {32'd0, 31'd10, 1'b1});
    #2 rst = 1'b1;
    #1 check("rst in end", {result_o[62:0], ready_o}, 64'h0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_div("u 9/3 after end rst", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 Parameters: none; the datapath is fixed at 32-bit operands and a 64-bit result.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start.
REQ-006 opdata1_i  in  32  dividend; sampled at start.
REQ-007 opdata2_i  in  32  divisor; sampled at start.
REQ-008 start_i  in  1  EX-stage request, held high until the result is consumed.
REQ-009 annul_i  in  1  cancel request (flush/branch-delay kill).
REQ-010 result_o  out  64  {remainder[63:32], quotient[31:0]}, registered.
REQ-011 ready_o  out  1  result_o valid; EX stage releases its stall request on this signal.

Function
REQ-012 The block SHALL implement states FREE, BYZERO, ON and END, and SHALL use a 6-bit iteration counter cnt.
REQ-013 FREE: on start_i=1 and annul_i=0, the block SHALL latch the operands; next state is BYZERO if divisor==0, else ON with cnt=0.
REQ-014 FREE: if start_i=0, or annul_i=1, the block SHALL stay in FREE with ready_o=0 and result_o=0.
REQ-015 For a signed operation, the block SHALL latch the two's-complement absolute values of negative operands, and SHALL record the dividend sign and the quotient sign (dividend sign XOR divisor sign).
REQ-016 BYZERO: on the next edge, the block SHALL go to END with result_o=64'h0 and ready_o=1.
REQ-017 ON: each edge SHALL perform one restoring shift-subtract iteration on a 65-bit partial-remainder/quotient register and increment cnt, for cnt = 0..31.
REQ-018 Iteration rule: shift the partial register left by 1 and trial-subtract the divisor from its upper 33 bits. If the result is non-negative, replace the upper bits and set quotient bit 1; otherwise set quotient bit 0.
REQ-019 ON with cnt==32: on that edge, the block SHALL apply sign correction. The quotient is negated if the quotient sign is set. The remainder is negated if the dividend sign is set (signed only). The block SHALL then load result_o, set ready_o=1 and go to END.
REQ-020 Latency SHALL be fixed: ready_o rises 34 edges after the start-sampling edge for a non-zero divisor, and 2 edges after it for a zero divisor.
REQ-021 END: the block SHALL hold result_o and ready_o=1 while start_i=1. On an edge with start_i=0, it SHALL go to FREE with ready_o=0 and result_o=0.
REQ-022 annul_i=1 in ON or BYZERO SHALL return the block to FREE on the next edge with ready_o=0, result_o=0 and cnt=0; no result is produced.
REQ-023 annul_i in END SHALL be ignored; only start_i releases END.
REQ-024 Operand changes after the start-sampling edge SHALL NOT affect the result.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL wrap: quotient 0x80000000, remainder 0x00000000.
REQ-026 A restart is not possible while in ON or END. A new division starts only from FREE, at the earliest one edge after END is left.
REQ-027 result_o and ready_o SHALL be driven only from registers, with no combinational path from any input.

Reset
REQ-028 On rst=1, the block SHALL immediately, independent of clk, set state=FREE, cnt=0, the internal partial register to 0, result_o=64'h0 and ready_o=0.
REQ-029 Reset asserted mid-ON or mid-END SHALL abandon the operation. After rst is released, the block SHALL accept a new start on the first edge.

Verification
REQ-030 Unsigned 100/7, start held -> ready_o=1 at edge 34; result_o={32'd2, 32'd14}; start_i low -> FREE next edge, outputs 0.
REQ-031 Signed -7/2 (0xFFFFFFF9, 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
REQ-032 Divisor 0 (any dividend, either mode) -> ready_o=1 at edge 2 with result_o=0; no ON iterations.
REQ-033 annul_i pulsed at edge 10 of ON -> FREE at edge 11, ready_o never asserts. An immediately following 0xFFFFFFFF/0x10 unsigned -> quotient 0x0FFFFFFF, remainder 0xF.
REQ-034 Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0 at edge 34.
REQ-035 rst asserted between edges at cnt=20 -> outputs 0 before the next edge; after release, 9/3 unsigned -> result {0, 3} at edge 34.
